// File: rtl/motion_sequencer_if.sv
// Command handshake and motor-driver bus for motion_sequencer.
// The master side is the environment (command source and motor driver);
// the slave side is the sequencer.
interface motion_sequencer_if;
    logic               cmd_valid;
    logic               cmd_ready;
    logic signed [23:0] cmd_target;
    logic [15:0]        cmd_speed;
    logic               pwm_end;
    logic signed [23:0] pwm_target;
    logic [15:0]        pwm_speed;

    modport master (
        output cmd_valid, cmd_target, cmd_speed, pwm_end,
        input  cmd_ready, pwm_target, pwm_speed
    );

    modport slave (
        input  cmd_valid, cmd_target, cmd_speed, pwm_end,
        output cmd_ready, pwm_target, pwm_speed
    );
endinterface

// File: rtl/motion_sequencer.sv
// Motion sequencer: queues absolute move commands and hands them one at a
// time to a motor driver, waiting for the driver to start and finish each
// move. A level abort stops the motor and flushes the queue.
module motion_sequencer #(
    parameter int FIFO_DEPTH    = 4,
    parameter int START_TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    motion_sequencer_if.slave           bus,
    input  logic                        abort,
    output logic                        busy,
    output logic                        done_pulse,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [15:0]                 moves_done
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TMR_W = $clog2(START_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(START_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StStartWait,
        StRun,
        StDone,
        StStopping
    } state_e;

    state_e             state_q;
    logic [TMR_W-1:0]   timer_q;
    logic signed [23:0] pwm_target_q;
    logic [15:0]        pwm_speed_q;
    logic               done_pulse_q;
    logic [15:0]        moves_done_q;

    // Command queue: {target, speed} per entry
    logic [39:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               push;
    logic               pop;
    logic [39:0]        head;

    // Ready depends only on the registered count, so a pop this cycle never frees a slot early
    assign bus.cmd_ready = (count_q < DEPTH_C) & ~abort;
    assign push          = bus.cmd_valid & bus.cmd_ready;
    assign pop           = (state_q == StIssue) & ~abort;
    assign head          = mem_q[rd_ptr_q];

    assign bus.pwm_target = pwm_target_q;
    assign bus.pwm_speed  = pwm_speed_q;
    assign done_pulse     = done_pulse_q;
    assign moves_done     = moves_done_q;
    assign fifo_count     = count_q;
    assign busy           = (state_q != StIdle) || (count_q != '0);

    // Queue storage write; entries need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.cmd_target, bus.cmd_speed};
        end
    end

    // Queue pointers and occupancy; abort empties the queue outright
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (abort) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Move sequencing FSM with registered driver outputs and completion pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            pwm_target_q <= '0;
            pwm_speed_q  <= '0;
            done_pulse_q <= 1'b0;
            moves_done_q <= '0;
        end else begin
            done_pulse_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // A same-cycle abort has just emptied the queue, so nothing to issue
                    if ((count_q != '0) && bus.pwm_end && !abort) begin
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    if (abort) begin
                        pwm_speed_q <= '0;
                        state_q     <= StStopping;
                    end else begin
                        pwm_target_q <= head[39:16];
                        pwm_speed_q  <= head[15:0];
                        timer_q      <= '0;
                        state_q      <= StStartWait;
                    end
                end
                StStartWait: begin
                    if (abort) begin
                        pwm_speed_q <= '0;
                        state_q     <= StStopping;
                    end else if (!bus.pwm_end) begin
                        state_q <= StRun;
                    end else if (timer_q == TMR_LAST) begin
                        // Driver never left idle: treat as a zero-length move
                        done_pulse_q <= 1'b1;
                        state_q      <= StDone;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                StRun: begin
                    if (abort) begin
                        pwm_speed_q <= '0;
                        state_q     <= StStopping;
                    end else if (bus.pwm_end) begin
                        done_pulse_q <= 1'b1;
                        state_q      <= StDone;
                    end
                end
                StDone: begin
                    moves_done_q <= moves_done_q + 16'd1;
                    state_q      <= StIdle;
                end
                StStopping: begin
                    if (bus.pwm_end) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_motion_sequencer.sv
// Bench for motion_sequencer: directed scenarios plus randomized command
// bursts and motor timing, checked against a queue-based reference model.
module tb_motion_sequencer;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        abort;
    logic        busy;
    logic        done_pulse;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [15:0] moves_done;

    motion_sequencer_if bus_if ();

    motion_sequencer #(
        .FIFO_DEPTH    (DEPTH),
        .START_TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus_if.slave),
        .abort      (abort),
        .busy       (busy),
        .done_pulse (done_pulse),
        .fifo_count (fifo_count),
        .moves_done (moves_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: pending commands and what the driver should currently see
    logic [39:0]        q[$];
    logic signed [23:0] exp_t;
    logic [15:0]        exp_s;
    logic [15:0]        exp_moves;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rand_speed();
        return 16'($urandom_range(1, 65535));
    endfunction

    // One clock: optionally offer a command, optionally mark this edge as the pop edge
    task automatic step(input bit want_push, input bit pop,
                        input logic signed [23:0] t, input logic [15:0] s);
        bit exp_rdy;
        logic [39:0] e;
        bus_if.cmd_valid  = want_push;
        bus_if.cmd_target = t;
        bus_if.cmd_speed  = s;
        #1;
        exp_rdy = (q.size() < DEPTH) && !abort;
        check("cmd_ready", bus_if.cmd_ready, exp_rdy);
        @(posedge clk);
        #1;
        if (abort) begin
            q.delete();
        end else begin
            if (pop && q.size() > 0) begin
                e = q.pop_front();
                exp_t = e[39:16];
                exp_s = e[15:0];
            end
            if (want_push && exp_rdy) q.push_back({t, s});
        end
        bus_if.cmd_valid = 1'b0;
        check("fifo_count", fifo_count, q.size());
    endtask

    task automatic rstep(input bit push_rand, input bit pop);
        bit p;
        p = push_rand && ($urandom_range(0, 3) == 0);
        step(p, pop, 24'($urandom), rand_speed());
    endtask

    task automatic hold_chk(input string tag);
        check({tag, "_target"}, bus_if.pwm_target, exp_t);
        check({tag, "_speed"}, bus_if.pwm_speed, exp_s);
    endtask

    // Starts with the sequencer idle, queue non-empty, pwm_end=1; ends idle after DONE
    task automatic do_move(input int d1, input int run_len, input bit zero_len,
                           input bit push_rand);
        rstep(push_rand, 1'b0);
        rstep(push_rand, 1'b1);
        hold_chk("issue");
        check("issue_busy", busy, 1'b1);
        check("issue_done", done_pulse, 1'b0);
        if (zero_len) begin
            for (int i = 1; i <= TMO; i++) begin
                rstep(push_rand, 1'b0);
                check("zl_done", done_pulse, (i == TMO));
                hold_chk("zl");
            end
        end else begin
            repeat (d1) begin
                rstep(push_rand, 1'b0);
                check("sw_done", done_pulse, 1'b0);
            end
            bus_if.pwm_end = 1'b0;
            rstep(push_rand, 1'b0);
            for (int i = 1; i < run_len; i++) begin
                rstep(push_rand, 1'b0);
                check("run_done", done_pulse, 1'b0);
                hold_chk("run");
            end
            bus_if.pwm_end = 1'b1;
            rstep(push_rand, 1'b0);
            check("done_pulse", done_pulse, 1'b1);
            hold_chk("done");
        end
        exp_moves = exp_moves + 16'd1;
        rstep(push_rand, 1'b0);
        check("idle_done", done_pulse, 1'b0);
        check("moves_done", moves_done, exp_moves);
        check("idle_busy", busy, (q.size() > 0));
    endtask

    initial begin
        int nmoves;
        reset_n           = 1'b0;
        abort             = 1'b0;
        bus_if.cmd_valid  = 1'b0;
        bus_if.cmd_target = '0;
        bus_if.cmd_speed  = '0;
        bus_if.pwm_end    = 1'b1;
        exp_t     = '0;
        exp_s     = '0;
        exp_moves = '0;
        #1;
        check("rst_target", bus_if.pwm_target, 24'd0);
        check("rst_speed", bus_if.pwm_speed, 16'd0);
        check("rst_done", done_pulse, 1'b0);
        check("rst_moves", moves_done, 16'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_count", fifo_count, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", bus_if.cmd_ready, 1'b1);

        // Abort together with an offered command while idle: command dropped
        abort = 1'b1;
        step(1'b1, 1'b0, 24'sd55, 16'h0033);
        abort = 1'b0;
        check("abort_idle_target", bus_if.pwm_target, 24'd0);
        check("abort_idle_speed", bus_if.pwm_speed, 16'd0);
        check("abort_idle_busy", busy, 1'b0);

        // Single move held for 50 cycles
        bus_if.pwm_end = 1'b0;
        step(1'b1, 1'b0, 24'sd100, 16'h0200);
        bus_if.pwm_end = 1'b1;
        do_move(2, 50, 1'b0, 1'b0);
        check("single_target", bus_if.pwm_target, 24'd100);
        check("single_speed", bus_if.pwm_speed, 16'h0200);
        check("single_moves", moves_done, 16'd1);

        // Zero-length move: driver never drops pwm_end
        step(1'b1, 1'b0, 24'sd0, 16'h0100);
        do_move(0, 0, 1'b1, 1'b0);

        // Queue fill: five offers, four accepted
        bus_if.pwm_end = 1'b0;
        repeat (5) step(1'b1, 1'b0, 24'($urandom), rand_speed());
        check("fill_count", fifo_count, 4);
        bus_if.pwm_end = 1'b1;
        do_move(1, 2, 1'b0, 1'b0);
        while (q.size() > 0) do_move(0, 1, 1'b0, 1'b0);

        // Randomized bursts and driver timing, including back-to-back moves
        for (int round = 0; round < 8; round++) begin
            bus_if.pwm_end = 1'b0;
            repeat ($urandom_range(1, 6)) rstep(1'b1, 1'b0);
            repeat ($urandom_range(0, 2)) step(1'b1, 1'b0, 24'($urandom), rand_speed());
            bus_if.pwm_end = 1'b1;
            nmoves = 0;
            while (q.size() > 0) begin
                do_move($urandom_range(0, 4), $urandom_range(1, 8),
                        ($urandom_range(0, 5) == 0), (nmoves < 3));
                nmoves++;
            end
        end

        // Abort while running with two queued
        bus_if.pwm_end = 1'b0;
        repeat (3) step(1'b1, 1'b0, 24'($urandom), rand_speed());
        bus_if.pwm_end = 1'b1;
        step(1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b1, '0, '0);
        hold_chk("ab_issue");
        bus_if.pwm_end = 1'b0;
        step(1'b0, 1'b0, '0, '0);
        check("ab_queued", fifo_count, 2);
        abort = 1'b1;
        step(1'b1, 1'b0, 24'($urandom), rand_speed());
        abort = 1'b0;
        exp_s = '0;
        hold_chk("ab_stop");
        repeat (3) begin
            step(1'b0, 1'b0, '0, '0);
            check("stop_done", done_pulse, 1'b0);
            hold_chk("stop");
        end
        step(1'b1, 1'b0, 24'($urandom), rand_speed());
        bus_if.pwm_end = 1'b1;
        step(1'b0, 1'b0, '0, '0);
        check("stop_exit_done", done_pulse, 1'b0);
        check("stop_moves", moves_done, exp_moves);
        hold_chk("stop_exit");
        do_move(1, 3, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a move
        bus_if.pwm_end = 1'b0;
        step(1'b1, 1'b0, 24'($urandom), rand_speed());
        bus_if.pwm_end = 1'b1;
        step(1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b1, '0, '0);
        bus_if.pwm_end = 1'b0;
        step(1'b0, 1'b0, '0, '0);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_target", bus_if.pwm_target, 24'd0);
        check("mid_rst_speed", bus_if.pwm_speed, 16'd0);
        check("mid_rst_done", done_pulse, 1'b0);
        check("mid_rst_moves", moves_done, 16'd0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_count", fifo_count, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/motion_sequencer.md
MOTION_SEQUENCER -- requirements
Module: motion_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command queue depth (power of two, 2..16).
REQ-002 SHALL have parameter START_TIMEOUT, default 16, clk cycles to wait for pwm_end to fall after issuing a move.
REQ-003 SHALL have port clk, input, 1, single clock for all logic.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port cmd_valid, input, 1, command offered.
REQ-006 SHALL have port cmd_ready, output, 1, command accepted when cmd_valid&cmd_ready.
REQ-007 SHALL have port cmd_target, input, 24, signed absolute step target.
REQ-008 SHALL have port cmd_speed, input, 16, speed word (nonzero; 0 is reserved for stop).
REQ-009 SHALL have port abort, input, 1, level; stop motion and flush queue.
REQ-010 SHALL have port pwm_end, input, 1, motor idle flag from the motor driver.
REQ-011 SHALL have port pwm_target, output, 24, signed target to the motor driver.
REQ-012 SHALL have port pwm_speed, output, 16, speed to the motor driver.
REQ-013 SHALL have ports busy (out, 1), done_pulse (out, 1), fifo_count (out, $clog2(FIFO_DEPTH)+1), moves_done (out, 16).

Function
REQ-014 SHALL store accepted {cmd_target, cmd_speed} in a FIFO; cmd_ready = (fifo_count < FIFO_DEPTH) & ~abort, registered-count based; a pop in the same cycle does not raise cmd_ready.
REQ-015 SHALL implement states IDLE, ISSUE, START_WAIT, RUN, DONE, STOPPING.
REQ-016 IDLE: if fifo_count>0 and pwm_end=1 -> ISSUE; otherwise remain.
REQ-017 ISSUE (1 cycle): pop head; drive pwm_target and pwm_speed from it; clear the start counter; -> START_WAIT.
REQ-018 START_WAIT: if pwm_end=0 -> RUN; elif the counter reaches START_TIMEOUT-1 -> DONE (zero-length move); else increment the counter.
REQ-019 RUN: pwm_target and pwm_speed held constant; on pwm_end=1 -> DONE.
REQ-020 DONE (1 cycle): done_pulse=1; moves_done increments by 1, wrapping 0xFFFF->0; -> IDLE.
REQ-021 Back-to-back: with the FIFO non-empty, ISSUE of the next command occurs 2 cycles after DONE (DONE -> IDLE -> ISSUE).
REQ-022 busy = 1 in every state except IDLE, or whenever fifo_count>0.
REQ-023 abort=1 in any state: flush the FIFO (count=0) in that cycle; the push in that cycle is dropped.
REQ-024 abort in ISSUE/START_WAIT/RUN: pwm_speed <= 0, pwm_target unchanged; -> STOPPING.
REQ-025 abort in IDLE or DONE: flush only; state follows the normal path; the DONE pulse still counts.
REQ-026 STOPPING: wait for pwm_end=1 -> IDLE; no done_pulse; moves_done unchanged; pwm_speed stays 0 until the next ISSUE.
REQ-027 Commands arriving while abort=0 in any state (including STOPPING) are queued normally.
REQ-028 pwm_target and pwm_speed SHALL be registers changing only in ISSUE, on abort, or on reset.

Reset
REQ-029 On reset_n=0 (asynchronous, any state, mid-move included): state=IDLE, FIFO empty, pwm_target=0, pwm_speed=0, done_pulse=0, moves_done=0, busy=0, counter=0.
REQ-030 After reset release, cmd_ready=1 on the first clk edge.

Verification
REQ-031 Single move: push {100, 0x0200}, pwm_end falls 3 cycles after ISSUE and rises 50 cycles later -> pwm_target=100, pwm_speed=0x0200 held throughout; one done_pulse; moves_done=1.
REQ-032 Queue fill: push 5 commands with pwm_end held 0 -> 4 accepted, cmd_ready=0 on the 5th; fifo_count=4 then 3 after the first ISSUE.
REQ-033 Zero-length move: push {0, 0x0100}, pwm_end held 1 -> done_pulse exactly START_TIMEOUT+1 cycles after ISSUE.
REQ-034 Abort in RUN with 2 queued: pulse abort -> fifo_count=0; pwm_speed=0; no done_pulse; IDLE after pwm_end rises; moves_done unchanged.
REQ-035 Simultaneous abort and cmd_valid in IDLE -> command dropped; fifo_count=0; pwm outputs unchanged.
REQ-036 Reset asserted mid-RUN -> all outputs at reset values immediately, without waiting for a clk edge.
